// File: rtl/hps_master_bytes_to_packets_pkg.sv
// Shared constants and decoder state for the HPS master byte <-> packet channel path.
// Used by the bytes-to-packets decoder, the packets-to-bytes encoder and their benches.
package hps_master_bytes_to_packets_pkg;

  localparam logic [7:0] SOP_CHAR    = 8'h7A;
  localparam logic [7:0] EOP_CHAR    = 8'h7B;
  localparam logic [7:0] CHAN_CHAR   = 8'h7C;
  localparam logic [7:0] ESC_CHAR    = 8'h7D;
  localparam logic [7:0] ESCAPE_XOR  = 8'h20;

  typedef enum logic [1:0] {
    ST_DATA     = 2'd0,
    ST_ESC      = 2'd1,
    ST_CHAN     = 2'd2,
    ST_CHAN_ESC = 2'd3
  } b2p_state_e;

  // True for any byte that has framing meaning on the link.
  function automatic logic is_special(input logic [7:0] b);
    return (b == SOP_CHAR) || (b == EOP_CHAR) || (b == CHAN_CHAR) || (b == ESC_CHAR);
  endfunction

endpackage

// File: rtl/hps_master_st_out_reg.sv
// One-entry registered Avalon-ST output stage: holds a beat until the sink takes it.
module hps_master_st_out_reg #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_load,
  input  logic [7:0]               i_data,
  input  logic                     i_sop,
  input  logic                     i_eop,
  input  logic [CHANNEL_WIDTH-1:0] i_channel,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [7:0]               o_data,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic [CHANNEL_WIDTH-1:0] o_channel
);

  logic                     r_valid;
  logic [7:0]               r_data;
  logic                     r_sop;
  logic                     r_eop;
  logic [CHANNEL_WIDTH-1:0] r_channel;

  // The caller only loads when the slot is empty or being drained this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_channel <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_data    <= i_data;
      r_sop     <= i_sop;
      r_eop     <= i_eop;
      r_channel <= i_channel;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_sop     = r_sop;
  assign o_eop     = r_eop;
  assign o_channel = r_channel;

endmodule

// File: rtl/hps_master_bytes_to_packets.sv
// Decodes the escaped host-link byte stream into Avalon-ST packets with SOP/EOP/channel.
// Optional macro HPS_B2P_CHANNEL_FILTER_EN: drop beats not addressed to CHANNEL_ID.
module hps_master_bytes_to_packets
  import hps_master_bytes_to_packets_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNEL_ID    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel
);

`ifdef HPS_B2P_CHANNEL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif
  localparam logic [CHANNEL_WIDTH-1:0] ID_CH = CHANNEL_WIDTH'(CHANNEL_ID);

  function automatic logic [CHANNEL_WIDTH-1:0] to_chan(input logic [7:0] b);
    return CHANNEL_WIDTH'(b);
  endfunction

  b2p_state_e               r_state;
  b2p_state_e               w_state_nxt;
  logic                     r_sop_pending;
  logic                     r_eop_pending;
  logic [CHANNEL_WIDTH-1:0] r_channel;

  logic                     w_accept;
  logic                     w_payload;
  logic                     w_emit;
  logic [7:0]               w_byte;
  logic                     w_set_sop;
  logic                     w_set_eop;
  logic                     w_chan_ld;
  logic                     w_out_valid;
  logic [CHANNEL_WIDTH-1:0] w_stage_chan;

  assign in_ready = !w_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_DATA;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_payload   = 1'b0;
    w_byte      = in_data;
    w_set_sop   = 1'b0;
    w_set_eop   = 1'b0;
    w_chan_ld   = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_DATA: begin
          if (in_data == SOP_CHAR)       w_set_sop   = 1'b1;
          else if (in_data == EOP_CHAR)  w_set_eop   = 1'b1;
          else if (in_data == CHAN_CHAR) w_state_nxt = ST_CHAN;
          else if (in_data == ESC_CHAR)  w_state_nxt = ST_ESC;
          else                           w_payload   = 1'b1;
        end
        ST_ESC: begin
          w_payload   = 1'b1;
          w_byte      = in_data ^ ESCAPE_XOR;
          w_state_nxt = ST_DATA;
        end
        ST_CHAN: begin
          if (in_data == ESC_CHAR) begin
            w_state_nxt = ST_CHAN_ESC;
          end else begin
            w_chan_ld   = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end
        ST_CHAN_ESC: begin
          w_chan_ld   = 1'b1;
          w_byte      = in_data ^ ESCAPE_XOR;
          w_state_nxt = ST_DATA;
        end
        default: w_state_nxt = ST_DATA;
      endcase
    end
  end

  // Pending flags clear on every payload beat, even a filtered one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sop_pending <= 1'b0;
      r_eop_pending <= 1'b0;
      r_channel     <= '0;
    end else begin
      if (w_payload) begin
        r_sop_pending <= 1'b0;
        r_eop_pending <= 1'b0;
      end else begin
        if (w_set_sop) r_sop_pending <= 1'b1;
        if (w_set_eop) r_eop_pending <= 1'b1;
      end
      if (w_chan_ld) r_channel <= to_chan(w_byte);
    end
  end

  assign w_emit = w_payload && (!FILTER_EN || (r_channel == ID_CH));

  hps_master_st_out_reg #(
    .CHANNEL_WIDTH (CHANNEL_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_emit),
    .i_data    (w_byte),
    .i_sop     (r_sop_pending),
    .i_eop     (r_eop_pending),
    .i_channel (r_channel),
    .i_ready   (out_ready),
    .o_valid   (w_out_valid),
    .o_data    (out_data),
    .o_sop     (out_startofpacket),
    .o_eop     (out_endofpacket),
    .o_channel (w_stage_chan)
  );

  assign out_valid   = w_out_valid;
  assign out_channel = FILTER_EN ? ID_CH : w_stage_chan;

endmodule

// File: tb/tb_hps_master_bytes_to_packets.sv
// Directed bench for hps_master_bytes_to_packets (framing, escapes, channel, backpressure, reset).
module tb_hps_master_bytes_to_packets;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;

  int checks = 0;
  int errors = 0;

  hps_master_bytes_to_packets #(
    .CHANNEL_WIDTH (8),
    .CHANNEL_ID    (0)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock with out_ready held high; sample 1ns after the edge.
  task automatic send(input logic [7:0] b);
    in_valid  = 1'b1;
    in_data   = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic s, input logic e,
                      input logic [7:0] c);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".sop"}, out_startofpacket, s);
    chk({tag, ".eop"}, out_endofpacket, e);
    chk({tag, ".chan"}, out_channel, c);
  endtask

  task automatic no_beat(input string tag);
    chk({tag, ".valid"}, out_valid, 1'b0);
  endtask

  // Backpressure scenario state
  logic [7:0] stream [6];
  logic [7:0] got_d [$];
  logic       got_s [$];
  logic       got_e [$];
  logic       m_valid, m_sop, m_eop, m_ps, m_pe, m_ready, acc;
  logic [7:0] m_data;
  int         idx;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.data", out_data, 8'h00);
    chk("rst.sop", out_startofpacket, 1'b0);
    chk("rst.eop", out_endofpacket, 1'b0);
    chk("rst.chan", out_channel, 8'h00);
    reset_n = 1'b1;
    idle();

    // Basic packet, one beat per cycle, one cycle latency
    send(8'h7A); no_beat("p1.sop_ctl");
    send(8'h11); beat("p1.b11", 8'h11, 1'b1, 1'b0, 8'h00);
    send(8'h22); beat("p1.b22", 8'h22, 1'b0, 1'b0, 8'h00);
    send(8'h7B); no_beat("p1.eop_ctl");
    send(8'h33); beat("p1.b33", 8'h33, 1'b0, 1'b1, 8'h00);
    idle();      no_beat("p1.drain");

    // Escapes, including escaped special bytes and an escaped raw special
    send(8'h7D); no_beat("esc1.ctl");
    send(8'h5A); beat("esc1", 8'h7A, 1'b0, 1'b0, 8'h00);
    send(8'h7D);
    send(8'h5D); beat("esc2", 8'h7D, 1'b0, 1'b0, 8'h00);
    send(8'h7D);
    send(8'h7A); beat("esc3", 8'h5A, 1'b0, 1'b0, 8'h00);

    // Repeated SOP is idempotent; escaped channel byte
    send(8'h7C);
    send(8'h7D);
    send(8'h5C);
    send(8'h7A);
    send(8'h7A); no_beat("ch.ctl");
    send(8'h44); beat("ch.b44", 8'h44, 1'b1, 1'b0, 8'h7C);
    send(8'h7C);
    send(8'h00); no_beat("ch.back0");

    // Backpressure: out_ready toggles every cycle, bench models the one-entry stage
    stream[0] = 8'h7A; stream[1] = 8'h01; stream[2] = 8'h02;
    stream[3] = 8'h03; stream[4] = 8'h7B; stream[5] = 8'h04;
    idle();
    m_valid = 1'b0; m_data = 8'h00; m_sop = 1'b0; m_eop = 1'b0;
    m_ps = 1'b0; m_pe = 1'b0; idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx >= 6 && !m_valid) break;
      out_ready = cyc[0];
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? stream[idx] : 8'h00;
      m_ready   = !m_valid || out_ready;
      #1;
      chk("bp.in_ready", in_ready, m_ready);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_s.push_back(out_startofpacket);
        got_e.push_back(out_endofpacket);
      end
      acc = in_valid && m_ready;
      if (acc && in_data != 8'h7A && in_data != 8'h7B) begin
        m_valid = 1'b1; m_data = in_data; m_sop = m_ps; m_eop = m_pe;
        m_ps = 1'b0; m_pe = 1'b0;
      end else begin
        if (out_ready) m_valid = 1'b0;
        if (acc && in_data == 8'h7A) m_ps = 1'b1;
        if (acc && in_data == 8'h7B) m_pe = 1'b1;
      end
      if (acc) idx++;
      @(posedge clk);
      #1;
      chk("bp.valid", out_valid, m_valid);
      if (m_valid) begin
        chk("bp.data", out_data, m_data);
        chk("bp.sop", out_startofpacket, m_sop);
        chk("bp.eop", out_endofpacket, m_eop);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.all_sent", idx, 6);
    chk("bp.count", got_d.size(), 4);
    if (got_d.size() == 4) begin
      chk("bp.d0", {got_d[0], 6'd0, got_s[0], got_e[0]}, {8'h01, 8'h02});
      chk("bp.d1", {got_d[1], 6'd0, got_s[1], got_e[1]}, {8'h02, 8'h00});
      chk("bp.d2", {got_d[2], 6'd0, got_s[2], got_e[2]}, {8'h03, 8'h00});
      chk("bp.d3", {got_d[3], 6'd0, got_s[3], got_e[3]}, {8'h04, 8'h01});
    end
    idle();

    // Stall hold: beat held stable while out_ready is low
    send(8'h66);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    #1;
    chk("hold.in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    beat("hold.b66", 8'h66, 1'b0, 1'b0, 8'h00);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    beat("hold.b77", 8'h77, 1'b0, 1'b0, 8'h00);
    idle();

    // Reset mid-escape discards SOP flag and escape state
    send(8'h7A);
    send(8'h7D);
    send(8'h10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst.valid", out_valid, 1'b0);
    chk("mid_rst.data", out_data, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    send(8'h7A); send(8'h7D);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    idle();
    send(8'h55); beat("post_rst", 8'h55, 1'b0, 1'b0, 8'h00);
    idle();

`ifdef HPS_B2P_CHANNEL_FILTER_EN
    send(8'h7C); send(8'h01); send(8'h7A);
    send(8'hAA); no_beat("flt.AA");
    send(8'h7B);
    send(8'hBB); no_beat("flt.BB");
    send(8'h7C); send(8'h00); send(8'h7A);
    send(8'hCC); beat("flt.CC", 8'hCC, 1'b1, 1'b0, 8'h00);
    idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
